// File: rtl/replay_arbiter_pkg.sv
// Shared types and width helpers for replay_arbiter.
//   state_t : arbiter FSM state (IDLE between sequences, LOCK while a grant is held)
//   tag_w   : owner-tag width for N requesters, never below 1 bit
//   cnt_w   : beat-counter width for LEN-item sequences, never below 1 bit
package replay_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    function automatic int tag_w(input int n);
        int c = $clog2(n);
        return (c < 1) ? 1 : c;
    endfunction

    function automatic int cnt_w(input int len);
        int c = $clog2(len);
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/replay_arbiter_if.sv
// Bundle of requester, replay_buffer and owner-tag signals around replay_arbiter.
//   idat/ivld/irdy        : N requester streams
//   bdat/bvld/brdy        : forwarded stream into the replay_buffer
//   buf_ovld/ordy/ofin    : monitored replay_buffer output handshake and end-of-sequence
//   otag/otag_vld         : owner of the sequence currently being replayed
//   busy                  : a sequence grant is held
// master = arbiter side, slave = requesters/buffer side.
interface replay_arbiter_if
    import replay_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 32
);
    localparam int TAG_W = tag_w(N);

    logic [N-1:0][W-1:0] idat;
    logic [N-1:0]        ivld;
    logic [N-1:0]        irdy;
    logic [W-1:0]        bdat;
    logic                bvld;
    logic                brdy;
    logic                buf_ovld;
    logic                buf_ordy;
    logic                buf_ofin;
    logic [TAG_W-1:0]    otag;
    logic                otag_vld;
    logic                busy;

    modport master (
        input  idat, ivld, brdy, buf_ovld, buf_ordy, buf_ofin,
        output irdy, bdat, bvld, otag, otag_vld, busy
    );

    modport slave (
        output idat, ivld, brdy, buf_ovld, buf_ordy, buf_ofin,
        input  irdy, bdat, bvld, otag, otag_vld, busy
    );

endinterface

// File: rtl/replay_arbiter_rr.sv
// Combinational requester pick for replay_arbiter.
//   req : per-requester valid
//   ptr : last granted requester (round-robin start point)
//   any : at least one request present
//   g   : chosen requester
// Macro REPLAY_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins,
// ptr ignored); otherwise the first requester after ptr wins, wrapping.
module replay_arb_rr
    import replay_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int TAG_W = tag_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [TAG_W-1:0] ptr,
    output logic             any,
    output logic [TAG_W-1:0] g
);

`ifdef REPLAY_ARB_FIXED_PRIO_EN
    always_comb begin
        any = 1'b0;
        g   = '0;
        // Descending scan: the last hit is the lowest index.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                any = 1'b1;
                g   = TAG_W'(i);
            end
        end
    end
`else
    logic [TAG_W-1:0] j;

    always_comb begin
        any = 1'b0;
        g   = '0;
        j   = '0;
        // Scan farthest-from-ptr first so the nearest requester after ptr
        // overwrites the result; k==N is ptr itself, lowest priority.
        for (int k = N; k >= 1; k--) begin
            j = TAG_W'((int'(ptr) + k) % N);
            if (req[j]) begin
                any = 1'b1;
                g   = j;
            end
        end
    end
`endif

endmodule

// File: rtl/replay_arbiter.sv
// Shares one replay_buffer input between N sequence producers. A requester is
// granted for a whole LEN-item sequence, its beats are forwarded to the buffer,
// and its tag is queued so the buffer consumer knows whose sequence replays.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : replay_arbiter_if.master (requesters, buffer, monitor, tags)
// Macro REPLAY_ARB_FIXED_PRIO_EN: fixed priority instead of round-robin.
module replay_arbiter
    import replay_arb_pkg::*;
#(
    parameter int N          = 4,
    parameter int LEN        = 8,
    parameter int W          = 32,
    parameter int TAGQ_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    replay_arbiter_if.master   bus
);

    localparam int TAG_W = tag_w(N);
    localparam int CNT_W = cnt_w(LEN);
    localparam int QA_W  = (TAGQ_DEPTH > 1) ? $clog2(TAGQ_DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);
    localparam logic [TAG_W-1:0] PTR_RST  = TAG_W'(N - 1);

    if (N < 1 || LEN < 1 || TAGQ_DEPTH < 1) begin : g_bad_cfg
        $fatal(1, "replay_arbiter: N, LEN and TAGQ_DEPTH must all be >= 1");
    end

    state_t           state;
    logic [TAG_W-1:0] grant, ptr, pick_g;
    logic             pick_any;
    logic [CNT_W-1:0] cnt;
    logic             beat, push, pop;

    // Tag queue: index plus generation MSB so full/empty are distinguishable.
    logic [TAG_W-1:0] tq [TAGQ_DEPTH];
    logic [QA_W:0]    wr_ptr, rd_ptr;
    logic             tq_empty, tq_full, pop_req;

    function automatic logic [QA_W:0] qinc(input logic [QA_W:0] p);
        if (p[QA_W-1:0] == QA_W'(TAGQ_DEPTH - 1))
            return {~p[QA_W], {QA_W{1'b0}}};
        return p + (QA_W + 1)'(1);
    endfunction

    replay_arb_rr #(.N(N), .TAG_W(TAG_W)) u_pick (
        .req (bus.ivld),
        .ptr (ptr),
        .any (pick_any),
        .g   (pick_g)
    );

    assign tq_empty = (wr_ptr == rd_ptr);
    assign tq_full  = (wr_ptr[QA_W-1:0] == rd_ptr[QA_W-1:0]) && (wr_ptr[QA_W] != rd_ptr[QA_W]);
    assign pop_req  = bus.buf_ovld && bus.buf_ordy && bus.buf_ofin;
    assign pop      = pop_req && !tq_empty;
    assign push     = (state == IDLE) && pick_any && !tq_full;
    assign beat     = (state == LOCK) && bus.ivld[grant] && bus.brdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= PTR_RST;
            grant  <= '0;
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            case (state)
                IDLE: if (push) begin
                    grant  <= pick_g;
                    cnt    <= '0;
                    state  <= LOCK;
                    wr_ptr <= qinc(wr_ptr);
                end
                LOCK: if (beat) begin
                    if (cnt == CNT_LAST) begin
                        // Return to IDLE costs one bubble cycle per sequence.
                        state <= IDLE;
`ifndef REPLAY_ARB_FIXED_PRIO_EN
                        ptr   <= grant;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
            if (pop) rd_ptr <= qinc(rd_ptr);
        end
    end

    // Tag storage needs no reset: otag is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) tq[wr_ptr[QA_W-1:0]] <= pick_g;
    end

    always_comb begin
        bus.irdy = '0;
        bus.bdat = '0;
        bus.bvld = 1'b0;
        if (state == LOCK) begin
            bus.bdat        = bus.idat[grant];
            bus.bvld        = bus.ivld[grant];
            bus.irdy[grant] = bus.brdy;
        end
    end

    assign bus.busy     = (state == LOCK);
    assign bus.otag_vld = !tq_empty;
    assign bus.otag     = tq_empty ? '0 : tq[rd_ptr[QA_W-1:0]];

    // An end-of-sequence pop with nothing queued means the buffer and the
    // arbiter disagree about what is in flight.
    a_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop_req && tq_empty))
        else $error("replay_arbiter: tag pop while tag queue empty");

endmodule
